bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
Cascadable multi-digit BCD counter. It generalises the single-digit decade counter to DIGITS decimal digits and adds count direction, count enable, a synchronous parallel load with BCD validation, and a terminal-count output for cascading. It also generalises the decoded-count control output to two run-time programmable compare values. It sits in the timing/sequencing datapath, for example as an event counter or a display counter feeding 7-segment decoders.

Parameters:
DIGITS, 2, number of BCD digits; q width is 4*DIGITS; legal range 1..8

Ports:
clk       input   1          rising-edge clock
rst       input   1          synchronous, active-high reset
en        input   1          count enable; counts one step per clk when high
up        input   1          direction: 1 = count up, 0 = count down
load      input   1          synchronous parallel load request
load_val  input   4*DIGITS   value to load; digit i is bits [4i+3:4i]
cmp_a     input   4*DIGITS   compare value A, BCD
cmp_b     input   4*DIGITS   compare value B, BCD
q         output  4*DIGITS   registered count, always valid BCD
tc        output  1          terminal count, combinational
ctrl      output  1          decoded match, combinational
load_err  output  1          registered flag for a rejected load

Behaviour:
- Clocking and reset:
  - All state changes occur on the rising edge of clk. Reset is synchronous and active-high.
  - Reset values: q = 0 (all digits 0), load_err = 0.
- Priority per edge: rst > load > en. An idle cycle holds q.
- Load:
  - The load is valid when every digit of load_val is ≤ 9. A valid load sets q <= load_val and load_err <= 0.
  - Any digit > 9 rejects the load: q is held and load_err <= 1.
  - load_err stays asserted for exactly one cycle. It is cleared by any edge that does not carry a rejected load, including reset.
  - Load wins over en on the same edge; no count step occurs on that edge.
- Count up (en=1, up=1, load=0):
  - Digit 0 increments every enabled edge.
  - Digit i (i>0) steps only when digits 0..i-1 are all 9.
  - A digit at 9 that steps wraps to 0. Full-range wrap: all-9 -> all-0.
- Count down (en=1, up=0, load=0):
  - Digit i steps only when digits 0..i-1 are all 0.
  - A digit at 0 that steps wraps to 9. Full-range wrap: all-0 -> all-9.
- Latency: q reflects a count, load or reset on the edge after the request, i.e. one cycle.
- Direction change: up is sampled on every edge. Toggling it mid-count takes effect on the next enabled edge, with no extra step and no skipped value.
- tc = en & (up ? q==all-9 : q==all-0).
  - tc is combinational from registered q and the live inputs.
  - For cascading: tc of stage n drives en of stage n+1, and the same up signal is shared by both stages.
  - tc is not gated by load or rst.
- ctrl = (q == cmp_a) | (q == cmp_b).
  - ctrl is combinational and independent of en.
  - A compare value containing any digit > 9 never matches.
  - If cmp_a == cmp_b, ctrl behaves as a single match.
- q never holds a non-BCD digit: reset and validated loads are the only ways to set it.
- Reset mid-count: q = 0 on the next edge regardless of load or en. tc and ctrl follow q combinationally.

Test Plan:
(All with DIGITS=2.)
1. Reset and up-count: rst 1 cycle, then en=1, up=1 for 100 cycles -> q steps 00,01,…,09,10,…,99,00; tc=1 only while q=0x99; the 09->10 carry is correct.
2. Down-count wrap: load 0x01, en=1, up=0 -> q goes 01,00,99,98; tc=1 only while q=0x00; flipping up=1 at q=98 -> next q=99.
3. Load validation: load_val=0x47 -> q=0x47, load_err=0. Then load_val=0x3A -> q stays 0x47, load_err=1 for exactly one cycle. Then load_val=0xF0 with en=1 -> q held, load_err=1.
4. Decoded control: cmp_a=0x07, cmp_b=0x11, counting up from 00 -> ctrl=1 exactly at q=07 and q=11 (each for 1 cycle of counting). Also cmp_b=0x1C -> only the 07 match fires.
5. Priority and simultaneous events:
   - load=1, en=1, load_val=0x55 -> q=0x55, not 0x56.
   - rst=1 with load=1 at q=0x33 -> q=0x00, load_err=0.
6. Cascade: two instances chained, tc0 -> en1, shared up, en0=1 -> combined 4-digit value counts 0099 -> 0100 -> … -> 9999 -> 0000 with no glitch steps on the upper stage.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-digit BCD up/down counter with validated parallel load,
// terminal-count output and two programmable decoded-match compare values.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   cmp_a,
    input  logic [4*DIGITS-1:0]   cmp_b,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  ctrl,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         loadErr_q, loadErr_d;
    logic [W-1:0] stepped;
    logic [3:0]   digit;
    logic         carry;
    logic         allNine, allZero;
    logic         loadValid, cmpAValid, cmpBValid;

    function automatic logic isBcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Ripple the carry/borrow from digit 0 upward; a digit steps only when all lower digits wrap.
    always_comb begin
        stepped = count_q;
        digit   = '0;
        carry   = 1'b1;
        allNine = 1'b1;
        allZero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (up) stepped[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                else    stepped[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            end
            carry   = carry & (up ? (digit == 4'd9) : (digit == 4'd0));
            allNine = allNine & (digit == 4'd9);
            allZero = allZero & (digit == 4'd0);
        end
    end

    always_comb begin
        loadValid = isBcd(load_val);
        cmpAValid = isBcd(cmp_a);
        cmpBValid = isBcd(cmp_b);
        count_d   = count_q;
        loadErr_d = 1'b0;
        if (load) begin
            if (loadValid) count_d   = load_val;
            else           loadErr_d = 1'b1;
        end else if (en) begin
            count_d = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            loadErr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            loadErr_q <= loadErr_d;
        end
    end

    assign q        = count_q;
    assign load_err = loadErr_q;
    assign tc       = en & (up ? allNine : allZero);
    assign ctrl     = (cmpAValid & (count_q == cmp_a)) | (cmpBValid & (count_q == cmp_b));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a decimal-integer model predicts each edge's result, which is
// queued at drive time and compared after the edge; combinational outputs are checked pre-edge.
module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [7:0] loadVal, cmpA, cmpB;
    logic [7:0] q;
    logic       tc, ctrl, loadErr;

    logic       cascRst, cascEn, cascUp, cascLoad;
    logic [15:0] cascLoadVal;
    logic [7:0] cascCmp;
    logic [7:0] cascQ0, cascQ1;
    logic       tc0, tc1, ctrl0, ctrl1, err0, err1;

    typedef struct {
        logic [7:0] q;
        logic       err;
    } expT;

    expT         expQ[$];
    logic [15:0] cascExpQ[$];

    int  checks   = 0;
    int  failures = 0;
    int  modelV   = 0;
    bit  modelKnown = 0;
    int  cascV    = 0;
    bit  cascKnown = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
        .cmp_a(cmpA), .cmp_b(cmpB), .q(q), .tc(tc), .ctrl(ctrl), .load_err(loadErr)
    );

    bcd_updown_counter #(.DIGITS(2)) casc0 (
        .clk(clk), .rst(cascRst), .en(cascEn), .up(cascUp), .load(cascLoad),
        .load_val(cascLoadVal[7:0]), .cmp_a(cascCmp), .cmp_b(cascCmp),
        .q(cascQ0), .tc(tc0), .ctrl(ctrl0), .load_err(err0)
    );

    bcd_updown_counter #(.DIGITS(2)) casc1 (
        .clk(clk), .rst(cascRst), .en(tc0), .up(cascUp), .load(cascLoad),
        .load_val(cascLoadVal[15:8]), .cmp_a(cascCmp), .cmp_b(cascCmp),
        .q(cascQ1), .tc(tc1), .ctrl(ctrl1), .load_err(err1)
    );

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit validBcd8(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int fromBcd8(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic int fromBcd16(input logic [15:0] v);
        return fromBcd8(v[15:8]) * 100 + fromBcd8(v[7:0]);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle on the single counter, check combinational outputs, queue the edge result.
    task automatic applyStimulus(input logic r, input logic l, input logic e, input logic u,
                                 input logic [7:0] lv);
        expT  ex;
        expT  got;
        logic expCtrl;
        rst = r; load = l; en = e; up = u; loadVal = lv;
        #2;
        if (modelKnown) begin
            checkOutput("tc", {15'd0, tc}, {15'd0, e & (u ? (modelV == 99) : (modelV == 0))});
            expCtrl = (validBcd8(cmpA) && toBcd(modelV) == {8'd0, cmpA}) ||
                      (validBcd8(cmpB) && toBcd(modelV) == {8'd0, cmpB});
            checkOutput("ctrl", {15'd0, ctrl}, {15'd0, expCtrl});
        end
        ex.err = 1'b0;
        if (r) begin
            modelV = 0;
            modelKnown = 1;
        end else if (l) begin
            if (validBcd8(lv)) modelV = fromBcd8(lv);
            else               ex.err = 1'b1;
        end else if (e) begin
            modelV = u ? (modelV + 1) % 100 : (modelV + 99) % 100;
        end
        ex.q = toBcd(modelV) & 16'h00ff;
        expQ.push_back(ex);
        @(posedge clk);
        #1;
        got = expQ.pop_front();
        checkOutput("q", {8'd0, q}, {8'd0, got.q});
        checkOutput("load_err", {15'd0, loadErr}, {15'd0, got.err});
    endtask

    task automatic cascadeStep(input logic r, input logic l, input logic e, input logic u,
                               input logic [15:0] lv);
        logic [15:0] exp16;
        cascRst = r; cascLoad = l; cascEn = e; cascUp = u; cascLoadVal = lv;
        #2;
        if (cascKnown)
            checkOutput("casc_tc", {15'd0, tc1}, {15'd0, e & (u ? (cascV == 9999) : (cascV == 0))});
        if (r) begin
            cascV = 0;
            cascKnown = 1;
        end else if (l) begin
            cascV = fromBcd16(lv);
        end else if (e) begin
            cascV = u ? (cascV + 1) % 10000 : (cascV + 9999) % 10000;
        end
        cascExpQ.push_back(toBcd(cascV));
        @(posedge clk);
        #1;
        exp16 = cascExpQ.pop_front();
        checkOutput("casc_q", {cascQ1, cascQ0}, exp16);
    endtask

    initial begin
        rst = 0; load = 0; en = 0; up = 1; loadVal = 8'h00;
        cmpA = 8'h07; cmpB = 8'h11;
        cascRst = 0; cascLoad = 0; cascEn = 0; cascUp = 1; cascLoadVal = 16'h0000; cascCmp = 8'h00;
        #1;

        // Reset then a full up-count lap with the 07/11 decode active.
        applyStimulus(1, 0, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 1, 1, 8'h00);

        // Invalid compare B must never match.
        cmpB = 8'h1C;
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, 1, 8'h00);

        // Down-count wrap and a direction flip.
        applyStimulus(0, 1, 0, 0, 8'h01);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 1, 8'h00);
        applyStimulus(0, 0, 0, 0, 8'h00);

        // Load validation and one-cycle error flag.
        applyStimulus(0, 1, 0, 1, 8'h47);
        applyStimulus(0, 1, 0, 1, 8'h3A);
        applyStimulus(0, 0, 0, 1, 8'h00);
        applyStimulus(0, 1, 1, 1, 8'hF0);
        applyStimulus(0, 0, 1, 1, 8'h00);

        // Priority: load over en, reset over load.
        applyStimulus(0, 1, 1, 1, 8'h55);
        applyStimulus(0, 1, 0, 1, 8'h33);
        applyStimulus(0, 1, 0, 1, 8'hAA);
        applyStimulus(1, 1, 1, 1, 8'h33);
        applyStimulus(0, 0, 1, 0, 8'h00);

        // Two-stage cascade.
        cascadeStep(1, 0, 0, 1, 16'h0000);
        cascadeStep(0, 1, 0, 1, 16'h0099);
        for (int i = 0; i < 3; i++) cascadeStep(0, 0, 1, 1, 16'h0000);
        cascadeStep(0, 1, 0, 1, 16'h9998);
        for (int i = 0; i < 3; i++) cascadeStep(0, 0, 1, 1, 16'h0000);
        for (int i = 0; i < 2; i++) cascadeStep(0, 0, 1, 0, 16'h0000);
        cascadeStep(0, 1, 0, 0, 16'h0100);
        for (int i = 0; i < 2; i++) cascadeStep(0, 0, 1, 0, 16'h0000);
        cascadeStep(0, 0, 0, 1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
